// File: rtl/rr_lzc_arbiter.sv
// Round-robin arbiter: one downstream valid/ready port shared by NumReq
// requesters. Priority starts one index above the last grant and wraps to 0.
// With LockIn set, an offered but ungranted selection is frozen until it is
// accepted, so the downstream side never sees the transaction change.

// Trailing-zero counter: index of the lowest set bit (0 when the vector is empty).
module rr_lzc_arbiter_tzc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] cnt
);
  // Scan from the top so the lowest set bit wins.
  always_comb begin
    cnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) cnt = W'(i);
  end
endmodule

module rr_lzc_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          LockIn    = 1'b1,
  parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NumReq-1:0]                req_i,
  output logic [NumReq-1:0]                gnt_o,
  input  logic [NumReq-1:0][DataWidth-1:0] data_i,
  output logic                             req_o,
  input  logic                             gnt_i,
  output logic [DataWidth-1:0]             data_o,
  output logic [IdxWidth-1:0]              idx_o
);

  if (NumReq == 1) begin : g_single
    // One requester: plain pass-through, nothing to remember.
    logic unused;
    assign unused = ^{clk_i, rst_ni, flush_i};
    assign req_o  = req_i[0];
    assign gnt_o  = gnt_i;
    assign data_o = data_i[0];
    assign idx_o  = '0;
  end else begin : g_arb
    logic [IdxWidth-1:0] rr_q, lock_idx_q;
    logic [IdxWidth-1:0] idx_masked, idx_all, sel;
    logic                lock_q;
    logic [NumReq-1:0]   mask, masked;

    // Only requesters strictly above the last grant are eligible first.
    for (genvar i = 0; i < NumReq; i++) begin : g_mask
      assign mask[i] = (rr_q < IdxWidth'(i));
    end
    assign masked = req_i & mask;

    rr_lzc_arbiter_tzc #(.N(NumReq), .W(IdxWidth)) u_tzc_masked (
      .vec (masked),
      .cnt (idx_masked)
    );
    rr_lzc_arbiter_tzc #(.N(NumReq), .W(IdxWidth)) u_tzc_all (
      .vec (req_i),
      .cnt (idx_all)
    );

    // Locked index wins; otherwise masked search, falling back to the wrap search.
    always_comb begin
      sel = idx_all;
      if (lock_q)       sel = lock_idx_q;
      else if (|masked) sel = idx_masked;
    end

    assign req_o = |req_i;
    assign idx_o = req_o ? sel : '0;

    // Payload mux and one-hot grant; mux via compare so data_o is never X.
    always_comb begin
      data_o = '0;
      gnt_o  = '0;
      for (int i = 0; i < NumReq; i++) begin
        if (idx_o == IdxWidth'(i)) data_o = data_i[i];
        gnt_o[i] = gnt_i & req_o & (idx_o == IdxWidth'(i));
      end
    end

    // Round-robin pointer: flush restores the reset value ahead of a handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             rr_q <= IdxWidth'(NumReq - 1);
      else if (flush_i)        rr_q <= IdxWidth'(NumReq - 1);
      else if (req_o && gnt_i) rr_q <= idx_o;
    end

    if (LockIn) begin : g_lock
      // Freeze the offered index until it is accepted or flushed.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          lock_q     <= 1'b0;
          lock_idx_q <= '0;
        end else if (flush_i || (req_o && gnt_i)) begin
          lock_q     <= 1'b0;
        end else if (req_o) begin
          lock_q     <= 1'b1;
          lock_idx_q <= idx_o;
        end
      end

      // A locked requester must hold its request until it is granted.
      a_lock_hold : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        lock_q |-> req_i[lock_idx_q]);
    end else begin : g_nolock
      assign lock_q     = 1'b0;
      assign lock_idx_q = '0;
    end
  end

endmodule

// File: tb/tb_rr_lzc_arbiter.sv
// Bench for rr_lzc_arbiter: a LockIn=1 and a LockIn=0 instance share stimulus.
// A behavioural model pushes expected outputs to a scoreboard when inputs are
// driven; entries are popped and compared after the combinational settle.
module tb_rr_lzc_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_ni, flush_i, gnt_i;
  logic [NR-1:0]           req_i;
  logic [NR-1:0][DW-1:0]   data_i;
  logic [1:0]              req_w;
  logic [1:0][NR-1:0]      gnt_w;
  logic [1:0][DW-1:0]      data_w;
  logic [1:0][IW-1:0]      idx_w;

  always #5 clk_i = ~clk_i;

  rr_lzc_arbiter #(.NumReq(NR), .DataWidth(DW), .LockIn(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i), .gnt_o(gnt_w[0]),
    .data_i(data_i), .req_o(req_w[0]), .gnt_i(gnt_i), .data_o(data_w[0]), .idx_o(idx_w[0])
  );
  rr_lzc_arbiter #(.NumReq(NR), .DataWidth(DW), .LockIn(1'b0)) dut_nl (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i), .gnt_o(gnt_w[1]),
    .data_i(data_i), .req_o(req_w[1]), .gnt_i(gnt_i), .data_o(data_w[1]), .idx_o(idx_w[1])
  );

  typedef struct {
    int            inst;
    logic          reqo;
    logic [IW-1:0] idx;
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_rr[2], m_lidx[2], m_idx[2], obs_idx[2];
  bit   m_lock[2];
  logic [NR-1:0] obs_gnt[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int k, input logic [NR-1:0] r);
    int  idx;
    int  c;
    bit  found;
    idx = 0;
    found = 1'b0;
    if (m_lock[k]) return m_lidx[k];
    for (int j = 1; j <= NR; j++) begin
      c = (m_rr[k] + j) % NR;
      if (!found && r[c]) begin
        idx = c;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rr[k] = NR - 1;
      m_lock[k] = 1'b0;
      m_lidx[k] = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.inst = k;
      e.reqo = |req_i;
      e.idx  = e.reqo ? IW'(pick(k, req_i)) : '0;
      e.gnt  = (e.reqo && gnt_i) ? NR'(1) << e.idx : '0;
      e.data = data_i[e.idx];
      m_idx[k] = int'(e.idx);
      sb.push_back(e);
    end
  endtask

  task automatic check_out();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("req_o[%0d]", e.inst), 64'(req_w[e.inst]), 64'(e.reqo));
      chk($sformatf("idx_o[%0d]", e.inst), 64'(idx_w[e.inst]), 64'(e.idx));
      chk($sformatf("gnt_o[%0d]", e.inst), 64'(gnt_w[e.inst]), 64'(e.gnt));
      chk($sformatf("data_o[%0d]", e.inst), 64'(data_w[e.inst]), 64'(e.data));
      obs_idx[e.inst] = int'(idx_w[e.inst]);
      obs_gnt[e.inst] = gnt_w[e.inst];
    end
  endtask

  task automatic model_clk();
    for (int k = 0; k < 2; k++) begin
      if (flush_i) begin
        m_rr[k] = NR - 1;
        m_lock[k] = 1'b0;
      end else if ((|req_i) && gnt_i) begin
        m_rr[k] = m_idx[k];
        m_lock[k] = 1'b0;
      end else if ((|req_i) && k == 0) begin
        m_lock[k] = 1'b1;
        m_lidx[k] = m_idx[k];
      end
    end
  endtask

  task automatic step(input logic [NR-1:0] r, input logic g, input logic f);
    req_i = r;
    gnt_i = g;
    flush_i = f;
    push_exp();
    check_out();
    @(posedge clk_i);
    model_clk();
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    req_i = '0;
    gnt_i = 1'b0;
    flush_i = 1'b0;
    for (int i = 0; i < NR; i++) data_i[i] = 32'hC0DE_0000 + DW'(i * 17);
    model_reset();

    // Reset state
    @(negedge clk_i);
    push_exp();
    check_out();
    chk("reset_req_o", 64'(req_w[0]), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fairness: strict rotation under full load
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("fair_idx", 64'(obs_idx[0]), 64'(i % NR));
      chk("fair_idx_nl", 64'(obs_idx[1]), 64'(i % NR));
    end

    // Masked priority and wrap
    step(4'b0100, 1'b1, 1'b0);
    chk("grant2", 64'(obs_idx[0]), 64'd2);
    step(4'b0011, 1'b1, 1'b0);
    chk("wrap_to_0", 64'(obs_idx[0]), 64'd0);
    step(4'b1011, 1'b1, 1'b0);
    chk("masked_1", 64'(obs_idx[0]), 64'd1);

    // Lock-in vs free-running selection
    step(4'b0000, 1'b0, 1'b1);
    repeat (3) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("offer2", 64'(obs_idx[0]), 64'd2);
    end
    step(4'b0101, 1'b0, 1'b0);
    chk("locked_2", 64'(obs_idx[0]), 64'd2);
    chk("unlocked_0", 64'(obs_idx[1]), 64'd0);
    step(4'b0101, 1'b1, 1'b0);
    chk("lock_gnt", 64'(obs_gnt[0]), 64'b0100);
    step(4'b0101, 1'b1, 1'b0);
    chk("after_lock", 64'(obs_idx[0]), 64'd0);

    // Flush vs handshake
    step(4'b0010, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    chk("flush_hs_idx", 64'(obs_idx[0]), 64'd3);
    step(4'b1111, 1'b1, 1'b0);
    chk("post_flush3", 64'(obs_idx[0]), 64'd0);
    step(4'b0010, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    chk("flush_prio", 64'(obs_idx[0]), 64'd0);

    // Flush vs lock update
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b0);
    chk("flush_nolock", 64'(obs_idx[0]), 64'd0);
    step(4'b0011, 1'b1, 1'b0);

    // Asynchronous reset while locked on 3
    step(4'b1000, 1'b0, 1'b0);
    req_i = 4'b1001;
    gnt_i = 1'b0;
    push_exp();
    check_out();
    chk("locked_3", 64'(obs_idx[0]), 64'd3);
    rst_ni = 1'b0;
    model_reset();
    push_exp();
    check_out();
    chk("async_rst_idx", 64'(obs_idx[0]), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(4'b1001, 1'b1, 1'b0);
    chk("post_rst_idx", 64'(obs_idx[0]), 64'd0);
    chk("post_rst_gnt", 64'(obs_gnt[0]), 64'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
